event_encoder4to2: RTL
======================

EVENT_ENCODER4TO2 -- requirements
Module: event_encoder4to2

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port en, input, 1 bit: event capture enable.
REQ-004 SHALL have port in, input, 4 bits: request lines, synchronous to clk, level-held by source.
REQ-005 SHALL have port ready, input, 1 bit: consumer accepts code this cycle.
REQ-006 SHALL have port code, output, 2 bits: binary index of the reported request line.
REQ-007 SHALL have port valid, output, 1 bit: code holds an unreported event.
REQ-008 SHALL have port overrun, output, 1 bit: one-cycle pulse, event lost.
REQ-009 SHALL define parameter N_LINES, default 4: request line count, fixed at 4 in this revision.
REQ-010 SHALL define parameter CODE_W, default 2: code width, equal to log2(N_LINES).

Function
REQ-011 SHALL register in into in_q every cycle; rise[i] = in[i] & ~in_q[i], combinational.
REQ-012 SHALL set pending[i] on a clock edge where rise[i]=1 and en=1; rises with en=0 SHALL be discarded.
REQ-013 SHALL keep draining pending events and holding valid/code while en=0.
REQ-014 SHALL select the highest set index of pending: bit 3 has priority over 2, over 1, over 0.
REQ-015 SHALL run FSM states IDLE (valid=0) and OUT (valid=1).
REQ-016 IDLE: if pending!=0, next edge SHALL load code=selected index, clear that pending bit, go to OUT; else stay IDLE.
REQ-017 OUT with ready=0: code and valid SHALL hold unchanged; pending SHALL keep accumulating.
REQ-018 OUT with ready=1 and pending!=0: same edge SHALL load the next selected index, clear its bit, stay OUT (back-to-back, one code per cycle).
REQ-019 OUT with ready=1 and pending=0: next edge SHALL clear valid and go to IDLE.
REQ-020 Latency: first edge sampling in[i]=1 sets pending; valid SHALL assert on the following edge (1 cycle) when IDLE and no higher-priority event is pending.
REQ-021 Rise on a bit already pending and not being cleared that edge: pending stays 1; overrun SHALL pulse high exactly one cycle later.
REQ-022 Rise on a bit being cleared (loaded into code) the same edge: set SHALL win, pending stays 1, no overrun.
REQ-023 Simultaneous rises on several lines SHALL all be captured and reported in priority order over successive handshakes.
REQ-024 A line held high SHALL produce exactly one event; it must return low for at least one cycle to re-arm.

Reset
REQ-025 rst_n=0 SHALL immediately force code=2'b00, valid=0, overrun=0, pending=0, state=IDLE, in_q=4'b1111.
REQ-026 Lines already high at reset release SHALL NOT generate events (in_q=1111).
REQ-027 Reset asserted mid-handshake SHALL drop all pending and presented events without an overrun pulse.

Structure
REQ-028 A shared package SHALL hold N_LINES, CODE_W and the FSM state enum (IDLE, OUT).
REQ-029 The priority select SHALL be a combinational sub-module pri_enc4 (in 4 bits -> idx 2 bits, any 1 bit), reusable by other encoders.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 Reset with in=4'b0100 held, release, run 5 cycles -> valid stays 0, overrun stays 0.
REQ-032 en=1, ready=1, pulse in=4'b0010 for 1 cycle -> valid=1 with code=2'b01 exactly one cycle after sampling, valid=0 the next cycle.
REQ-033 en=1, ready=0, rise in=4'b1011 in one cycle -> code=2'b11 held; then ready=1 -> codes 11, 01, 00 on three consecutive cycles, then valid=0.
REQ-034 ready=0 with bit 2 presented and bit 1 pending, then toggle in[1] 0->1 -> overrun single-cycle pulse, bit 1 reported once.
REQ-035 en=0, rise in=4'b0001 -> no valid; set en=1 with in held high -> still no event; drop then raise in[0] -> code=2'b00.
REQ-036 With valid=1, ready=0, pending=4'b0110, assert rst_n=0 mid-cycle -> valid=0 and code=2'b00 immediately; after release no events from the stale pending bits.

Source files
------------

// File: rtl/event_encoder4to2_pkg.sv
// Shared constants and FSM state encoding for the 4-to-2 event encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package event_encoder4to2_pkg;

    localparam int N_LINES = 4;
    localparam int CODE_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OUT  = 1'b1
    } state_t;

endpackage

// File: rtl/event_encoder4to2_pri_enc4.sv
// Combinational 4-line priority encoder, highest index wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module pri_enc4 (
    input  logic [3:0] in,
    output logic [1:0] idx,
    output logic       any
);

    always_comb begin
        idx = 2'd0;
        if (in[3]) begin
            idx = 2'd3;
        end else if (in[2]) begin
            idx = 2'd2;
        end else if (in[1]) begin
            idx = 2'd1;
        end
        any = |in;
    end

endmodule

// File: rtl/event_encoder4to2.sv
// Captures rising edges on 4 request lines and reports them as binary codes, highest line first.
// Latency: rise sampled on edge N -> valid/code on edge N+1 when idle.
// Backpressure: code/valid held while ready=0; new rises keep accumulating in pending, repeat rises flag overrun.
module event_encoder4to2
    import event_encoder4to2_pkg::*;
#(
    parameter int N_LINES = 4,
    parameter int CODE_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_LINES-1:0] in,
    input  logic              ready,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              overrun
);

    logic [N_LINES-1:0] in_q, in_d;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [N_LINES-1:0] rise, set_v, clr;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  sel_idx;
    logic               sel_any;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               load;
    state_t             state_q, state_d;

    pri_enc4 u_pri_enc4 (
        .in  (pending_q),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_comb begin
        in_d  = in;
        rise  = in & ~in_q;
        set_v = rise & {N_LINES{en}};

        // A new code is taken whenever the output slot is empty or being consumed this edge.
        load = sel_any && ((state_q == IDLE) || ready);

        clr = '0;
        if (load) begin
            clr[sel_idx] = 1'b1;
        end

        // Set after clear: a rise on the line being loaded re-arms it instead of being lost.
        pending_d = (pending_q & ~clr) | set_v;
        overrun_d = |(set_v & pending_q & ~clr);

        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        if (load) begin
            state_d = OUT;
            code_d  = sel_idx;
            valid_d = 1'b1;
        end else if ((state_q == OUT) && ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q      <= '1;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= IDLE;
        end else begin
            in_q      <= in_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule
